// File: rtl/led_pulse.sv
`default_nettype none
// ============================================================================
// Module      : led_pulse
// Description : Stretches single-cycle event strobes into human-visible pulses
//               with a guaranteed on time and off gap; events that arrive while
//               a pulse or gap is running are queued and replayed in order.
//               Optional sticky overflow flag: define LED_PULSE_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pulse #(
    parameter int ON_TIME     = 1000,
    parameter int OFF_TIME    = 1000,
    parameter int MAX_PENDING = 7,
    parameter bit INVERTED    = 1'b0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             trigger,
    output logic                             sigout,
    output logic                             busy,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending
`ifdef LED_PULSE_OVERFLOW_EN
    ,
    output logic                             overflow
`endif
);

    localparam int c_PW   = $clog2(MAX_PENDING + 1);
    localparam int c_TMAX = (ON_TIME > OFF_TIME) ? ON_TIME : OFF_TIME;
    localparam int c_TW   = ($clog2(c_TMAX) > 1) ? $clog2(c_TMAX) : 1;

    localparam logic [c_TW-1:0] c_ON_LOAD  = c_TW'(ON_TIME - 1);
    localparam logic [c_TW-1:0] c_OFF_LOAD = c_TW'(OFF_TIME - 1);
    localparam logic [c_PW-1:0] c_PEND_MAX = c_PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state_q;
    state_t          w_state_d;
    logic [c_TW-1:0] r_timer_q;
    logic [c_TW-1:0] w_timer_d;
    logic [c_PW-1:0] r_pending_q;
    logic [c_PW-1:0] w_pending_d;
    logic            r_sigout_q;
    logic            w_sigout_d;

    logic            w_start;
    logic            w_take_pending;
    logic            w_enqueue;
    logic            w_drop;

    always_comb begin
        w_state_d      = r_state_q;
        w_timer_d      = r_timer_q;
        w_pending_d    = r_pending_q;
        w_start        = 1'b0;
        w_take_pending = 1'b0;
        w_enqueue      = 1'b0;
        w_drop         = 1'b0;

        if (r_timer_q != '0) begin
            w_timer_d = r_timer_q - c_TW'(1);
        end

        case (r_state_q)
            S_IDLE: begin
                w_start = (r_pending_q != '0) || trigger;
            end
            S_ON: begin
                if (r_timer_q == '0) begin
                    w_state_d = S_GAP;
                    w_timer_d = c_OFF_LOAD;
                end
            end
            S_GAP: begin
                if (r_timer_q == '0) begin
                    if ((r_pending_q != '0) || trigger) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // The queued backlog is served before a fresh trigger, which then queues.
        w_take_pending = w_start && (r_pending_q != '0);
        if (w_start) begin
            w_state_d = S_ON;
            w_timer_d = c_ON_LOAD;
        end

        w_enqueue = trigger && !(w_start && !w_take_pending);
        w_drop    = w_enqueue && !w_take_pending && (r_pending_q == c_PEND_MAX);

        if (w_take_pending && !w_enqueue) begin
            w_pending_d = r_pending_q - c_PW'(1);
        end else if (w_enqueue && !w_take_pending && !w_drop) begin
            w_pending_d = r_pending_q + c_PW'(1);
        end

        w_sigout_d = (w_state_d == S_ON) ^ INVERTED;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_timer_q   <= '0;
            r_pending_q <= '0;
            r_sigout_q  <= INVERTED;
        end else begin
            r_state_q   <= w_state_d;
            r_timer_q   <= w_timer_d;
            r_pending_q <= w_pending_d;
            r_sigout_q  <= w_sigout_d;
        end
    end

    assign sigout  = r_sigout_q;
    assign pending = r_pending_q;
    assign busy    = (r_state_q != S_IDLE) || (r_pending_q != '0);

`ifdef LED_PULSE_OVERFLOW_EN
    logic r_overflow_q;
    logic w_overflow_d;

    assign w_overflow_d = r_overflow_q | w_drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_q <= 1'b0;
        end else begin
            r_overflow_q <= w_overflow_d;
        end
    end

    assign overflow = r_overflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pulse.sv
`default_nettype none
// Bench for led_pulse: event-timeline reference model plus scripted scenarios
// with literal expectations, followed by a long randomized run.
module tb_led_pulse;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int MAXP = 2;

    logic       clock;
    logic       reset;
    logic       trigger;
    logic       sig_a;
    logic       busy_a;
    logic [1:0] pend_a;
    logic       sig_b;
    logic       busy_b;
    logic [1:0] pend_b;
`ifdef LED_PULSE_OVERFLOW_EN
    logic       ovf_a;
    logic       ovf_b;
`endif

    led_pulse #(.ON_TIME(ON), .OFF_TIME(OFF), .MAX_PENDING(MAXP), .INVERTED(1'b0)) dut (
        .clock   (clock),
        .reset   (reset),
        .trigger (trigger),
        .sigout  (sig_a),
        .busy    (busy_a),
        .pending (pend_a)
`ifdef LED_PULSE_OVERFLOW_EN
        ,
        .overflow(ovf_a)
`endif
    );

    led_pulse #(.ON_TIME(ON), .OFF_TIME(OFF), .MAX_PENDING(MAXP), .INVERTED(1'b1)) dut_inv (
        .clock   (clock),
        .reset   (reset),
        .trigger (trigger),
        .sigout  (sig_b),
        .busy    (busy_b),
        .pending (pend_b)
`ifdef LED_PULSE_OVERFLOW_EN
        ,
        .overflow(ovf_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc    = 0;
    int base   = 0;
    int checks = 0;
    int errors = 0;
    bit model_valid = 1'b0;

    // Reference model: the start cycle of every accepted event's pulse.
    int m_start[$];
    int m_last = -1000000;
    bit m_ovf  = 1'b0;

    function automatic logic m_sig(input int c);
        logic r = 1'b0;
        foreach (m_start[i]) if (c >= m_start[i] && c <= m_start[i] + ON - 1) r = 1'b1;
        return r;
    endfunction

    function automatic logic m_busy(input int c);
        logic r = 1'b0;
        foreach (m_start[i]) if (c <= m_start[i] + ON + OFF - 1) r = 1'b1;
        return r;
    endfunction

    function automatic int m_pend(input int c);
        int n = 0;
        foreach (m_start[i]) if (m_start[i] > c) n++;
        return n;
    endfunction

    task automatic model_edge(input logic r, input logic t);
        int nxt;
        if (r) begin
            m_start.delete();
            m_last      = -1000000;
            m_ovf       = 1'b0;
            model_valid = 1'b1;
            return;
        end
        while (m_start.size() > 0 && m_start[0] + ON + OFF - 1 < cyc + 1) void'(m_start.pop_front());
        if (t) begin
            nxt = (cyc + 1 > m_last + ON + OFF) ? cyc + 1 : m_last + ON + OFF;
            if (nxt > cyc + 1 && m_pend(cyc + 1) >= MAXP) begin
                m_ovf = 1'b1;
            end else begin
                m_start.push_back(nxt);
                m_last = nxt;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d local=%0d got=%0d expected=%0d", name, cyc, cyc - base, got, exp);
        end
    endtask

    task automatic compare_all();
        logic s;
        s = m_sig(cyc);
        chk("model_sigout", 32'(sig_a), 32'(s));
        chk("model_sigout_inv", 32'(sig_b), 32'(!s));
        chk("model_busy", 32'(busy_a), 32'(m_busy(cyc)));
        chk("model_busy_inv", 32'(busy_b), 32'(m_busy(cyc)));
        chk("model_pending", 32'(pend_a), 32'(m_pend(cyc)));
        chk("model_pending_inv", 32'(pend_b), 32'(m_pend(cyc)));
`ifdef LED_PULSE_OVERFLOW_EN
        chk("model_overflow", 32'(ovf_a), 32'(m_ovf));
        chk("model_overflow_inv", 32'(ovf_b), 32'(m_ovf));
`endif
    endtask

    task automatic cycle(input logic r, input logic t);
        @(negedge clock);
        if (model_valid) compare_all();
        reset   = r;
        trigger = t;
        @(posedge clock);
        model_edge(r, t);
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0);
        base = cyc;
    endtask

    task automatic run_to(input int lc);
        while (cyc - base < lc) cycle(1'b0, 1'b0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        logic r, t;
        reset   = 1'b1;
        trigger = 1'b0;

        // Single trigger
        do_reset();
        #1;
        chk("rst_sigout", 32'(sig_a), 32'd0);
        chk("rst_sigout_inv", 32'(sig_b), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_pending", 32'(pend_a), 32'd0);
        run_to(10); cycle(1'b0, 1'b1); #1;
        chk("s1_first_on", 32'(sig_a), 32'd1);
        chk("s1_inv_on", 32'(sig_b), 32'd0);
        run_to(14); chk("s1_last_on", 32'(sig_a), 32'd1);
        run_to(15); chk("s1_off", 32'(sig_a), 32'd0);
        chk("s1_inv_off", 32'(sig_b), 32'd1);
        run_to(17); chk("s1_busy_gap", 32'(busy_a), 32'd1);
        run_to(18); chk("s1_idle", 32'(busy_a), 32'd0);

        // Three back-to-back triggers
        do_reset();
        run_to(10);
        repeat (3) cycle(1'b0, 1'b1);
        #1; chk("s2_pending2", 32'(pend_a), 32'd2);
        run_to(17); chk("s2_gap_end", 32'(sig_a), 32'd0);
        run_to(18); chk("s2_pulse2", 32'(sig_a), 32'd1);
        run_to(25); chk("s2_pulse3", 32'(sig_a), 32'd1);
        run_to(31); chk("s2_busy31", 32'(busy_a), 32'd1);
        run_to(32); chk("s2_idle32", 32'(busy_a), 32'd0);

        // Five triggers, two dropped
        do_reset();
        run_to(10);
        repeat (3) cycle(1'b0, 1'b1);
`ifdef LED_PULSE_OVERFLOW_EN
        #1; chk("s3_ovf_before", 32'(ovf_a), 32'd0);
`endif
        cycle(1'b0, 1'b1);
        #1; chk("s3_pend_sat", 32'(pend_a), 32'd2);
`ifdef LED_PULSE_OVERFLOW_EN
        chk("s3_ovf_set", 32'(ovf_a), 32'd1);
`endif
        cycle(1'b0, 1'b1);
        run_to(25); chk("s3_pulse3", 32'(sig_a), 32'd1);
        run_to(32); chk("s3_no_pulse4", 32'(sig_a), 32'd0);
        run_to(34); chk("s3_idle", 32'(busy_a), 32'd0);
`ifdef LED_PULSE_OVERFLOW_EN
        chk("s3_ovf_sticky", 32'(ovf_a), 32'd1);
`endif

        // Reset mid-pulse, trigger during reset
        do_reset();
        run_to(10); cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        #1;
        chk("s4_sigout", 32'(sig_a), 32'd0);
        chk("s4_busy", 32'(busy_a), 32'd0);
        chk("s4_pending", 32'(pend_a), 32'd0);
`ifdef LED_PULSE_OVERFLOW_EN
        chk("s4_ovf_clr", 32'(ovf_a), 32'd0);
`endif
        run_to(20); chk("s4_no_pulse", 32'(sig_a), 32'd0);

        // Trigger in the final gap cycle
        do_reset();
        run_to(10); cycle(1'b0, 1'b1);
        run_to(17); chk("s5_pend0", 32'(pend_a), 32'd0);
        cycle(1'b0, 1'b1);
        #1; chk("s5_direct_on", 32'(sig_a), 32'd1);
        chk("s5_pend_still0", 32'(pend_a), 32'd0);
        run_to(22); chk("s5_off", 32'(sig_a), 32'd0);

        // Randomized run with varying trigger density and occasional reset
        do_reset();
        p = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = $urandom_range(0, 100);
            r = ($urandom_range(0, 299) == 0);
            t = ($urandom_range(0, 99) < p);
            cycle(r, t);
        end
        run_to(cyc - base + 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
